// File: rtl/console_tx.sv
// Memory-mapped console output port: CPU stores queue bytes in a FIFO that drains to the host over valid/ready.
// Define CONSOLE_TX_CRLF_EN to expand each LF (8'h0A) into a CR,LF pair on the host side.
//
// state   | meaning
// IDLE    | nothing presented; tx_valid low
// SEND    | tx_data presented, waiting for tx_ready
// SEND_CR | CR presented in place of a popped LF (CONSOLE_TX_CRLF_EN only)
module console_tx #(
    parameter int          DEPTH = 16,
    parameter logic [15:0] ADDR  = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [15:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

`ifdef CONSOLE_TX_CRLF_EN
    typedef enum logic [1:0] {IDLE, SEND, SEND_CR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            overflow;

    logic            sel;
    logic            push;
    logic            push_ok;
    logic            pop;
    logic            rd;
    logic            full;
    logic            empty;
    logic [7:0]      head;
    logic            unused_wdata;

    assign sel     = (addr == ADDR);
    assign push    = we && sel;
    assign rd      = re && sel;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);
    assign unused_wdata = ^wdata[15:8];

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            SEND:    pop = tx_ready && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_comb begin
        rdata = 16'h0000;
        if (sel) begin
            rdata = {overflow, full, empty, 5'b00000, 8'(count)};
        end
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);

            // A dropped push on the same edge as a status read keeps the flag set.
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (rd) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_valid <= 1'b1;
`ifdef CONSOLE_TX_CRLF_EN
                        if (head == 8'h0A) begin
                            tx_data <= 8'h0D;
                            state   <= SEND_CR;
                        end else begin
                            tx_data <= head;
                            state   <= SEND;
                        end
`else
                        tx_data <= head;
                        state   <= SEND;
`endif
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (!empty) begin
`ifdef CONSOLE_TX_CRLF_EN
                            if (head == 8'h0A) begin
                                tx_data <= 8'h0D;
                                state   <= SEND_CR;
                            end else begin
                                tx_data <= head;
                            end
`else
                            tx_data <= head;
`endif
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
`ifdef CONSOLE_TX_CRLF_EN
                SEND_CR: begin
                    if (tx_ready) begin
                        tx_data <= 8'h0A;
                        state   <= SEND;
                    end
                end
`endif
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_console_tx.sv
// Directed bench for console_tx: expected host beats are queued when bytes are stored
// and compared by a negedge monitor as each valid/ready beat happens.
module tb_console_tx;

    localparam logic [15:0] CADDR = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] addr = CADDR;
    logic [15:0] wdata = 16'h0000;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [15:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int total = 0;
    int bad = 0;
    logic [7:0] sb[$];
    bit         hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    console_tx #(.DEPTH(16), .ADDR(CADDR)) dut (
        .clk(clk), .rstn(rstn), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Beats complete at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (!rstn) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 16'(tx_valid), 16'h0001);
                check("hold_data", 16'(tx_data), 16'(hold_d));
            end
            if (tx_valid && tx_ready) begin
                hold_v = 1'b0;
                if (sb.size() == 0) begin
                    check("beat_unexpected", 16'(tx_data), 16'hFFFF);
                end else begin
                    check("beat_data", 16'(tx_data), 16'(sb.pop_front()));
                end
            end else if (tx_valid) begin
                hold_v = 1'b1;
                hold_d = tx_data;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sb(input logic [7:0] b);
`ifdef CONSOLE_TX_CRLF_EN
        if (b == 8'h0A) sb.push_back(8'h0D);
`endif
        sb.push_back(b);
    endtask

    task automatic store(input logic [7:0] b, input bit accepted);
        we = 1'b1;
        wdata = {8'h5A, b};
        tick();
        we = 1'b0;
        if (accepted) push_sb(b);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (tx_valid || !rdata[13]); i++) tick();
        check({tag, "_status"}, rdata, 16'h2000);
        check({tag, "_valid"}, 16'(tx_valid), 16'h0000);
        check({tag, "_sb_left"}, 16'(sb.size()), 16'h0000);
    endtask

    initial begin
        // reset then idle
        rstn = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 16'(tx_valid), 16'h0000);
        check("rst_data", 16'(tx_data), 16'h0000);
        check("rst_status", rdata, 16'h2000);
        rstn = 1'b1;
        tick();
        addr = 16'h1234;
        #1;
        check("other_addr_rdata", rdata, 16'h0000);
        we = 1'b1;
        wdata = 16'h0055;
        tick();
        we = 1'b0;
        addr = CADDR;
        #1;
        check("other_addr_we_status", rdata, 16'h2000);
        tick();
        check("other_addr_we_valid", 16'(tx_valid), 16'h0000);

        // back-to-back 'H','i' with host ready
        tx_ready = 1'b1;
        store(8'h48, 1'b1);
        check("lat_valid_n", 16'(tx_valid), 16'h0000);
        store(8'h69, 1'b1);
        check("lat_valid_n1", 16'(tx_valid), 16'h0001);
        check("lat_data_n1", 16'(tx_data), 16'h0048);
        drain("hi");

        // host stalled: head popped into tx_data, 16 more fill the FIFO, the next is dropped
        tx_ready = 1'b0;
        for (int i = 0; i < 18; i++) store(8'(i), i <= 16);
        check("ovf_status", rdata, 16'hC010);
        check("ovf_valid", 16'(tx_valid), 16'h0001);
        check("ovf_data", 16'(tx_data), 16'h0000);
        addr = 16'h1234;
        re = 1'b1;
        tick();
        re = 1'b0;
        addr = CADDR;
        #1;
        check("ovf_wrong_addr_read", rdata, 16'hC010);
        re = 1'b1;
        tick();
        re = 1'b0;
        check("ovf_cleared", rdata, 16'h4010);

        // full FIFO, host ready and a store on the same edge
        tx_ready = 1'b1;
        store(8'hAA, 1'b1);
        check("full_push_status", rdata, 16'h4010);
        check("full_push_data", 16'(tx_data), 16'h0001);
        drain("full");

        // LF handling
        store(8'h0A, 1'b1);
        store(8'h41, 1'b1);
        drain("lf");

        // reset mid-transfer
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) store(8'h30 + 8'(i), 1'b1);
        check("pre_rst_status", rdata, 16'h0005);
        check("pre_rst_valid", 16'(tx_valid), 16'h0001);
        check("pre_rst_data", 16'(tx_data), 16'h0030);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", 16'(tx_valid), 16'h0000);
        check("mid_rst_status", rdata, 16'h2000);
        sb.delete();
        rstn = 1'b1;
        tx_ready = 1'b1;
        repeat (5) tick();
        check("post_rst_valid", 16'(tx_valid), 16'h0000);
        check("post_rst_status", rdata, 16'h2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
